// File: rtl/mcu_block_scheduler_if.sv
// Coefficient, table-generator and downstream block handshake bundle for the
// MCU block scheduler; master is the scheduler side, slave is its environment.
interface mcu_block_scheduler_if;
    logic       coef_valid;
    logic       coef_ready;
    logic       tg_is_new_coefficient;
    logic       tg_valid;
    logic       blk_valid;
    logic       blk_ready;
    logic [1:0] blk_comp;
    logic       blk_qsel;
    logic       blk_last;

    modport master (
        input  coef_valid, tg_valid, blk_ready,
        output coef_ready, tg_is_new_coefficient, blk_valid, blk_comp, blk_qsel, blk_last
    );

    modport slave (
        output coef_valid, tg_valid, blk_ready,
        input  coef_ready, tg_is_new_coefficient, blk_valid, blk_comp, blk_qsel, blk_last
    );
endinterface

// File: rtl/mcu_block_scheduler.sv
// Walks 4:2:0 MCUs (Y0..Y3, Cb, Cr) through the table generator one block at a time.
// Optional macro RESTART_INTERVAL_EN adds mid-image DC predictor resets every N MCUs.
module mcu_block_scheduler #(
    parameter int Y_BLOCKS  = 4,
    parameter int MCU_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MCU_CNT_W-1:0] total_mcus,
`ifdef RESTART_INTERVAL_EN
    input  logic [MCU_CNT_W-1:0] restart_interval,
`endif
    mcu_block_scheduler_if.master bus,
    output logic [MCU_CNT_W-1:0] mcu_count,
    output logic                 busy,
    output logic                 done,
    output logic                 dc_reset
);

    localparam int IDX_W = $clog2(Y_BLOCKS + 2);
    localparam logic [IDX_W-1:0] CB_IDX   = IDX_W'(Y_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Y_BLOCKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [MCU_CNT_W-1:0] total_q;
    logic [IDX_W-1:0]     blk_idx;
    logic                 pending;

    logic start_acc, tg_acc, blk_acc, is_last, mcu_end;
    logic restart_evt, restart_hold;

    assign start_acc = (state == ST_IDLE) & start;
    assign tg_acc    = (state == ST_RUN) & ~pending & bus.tg_valid;
    assign blk_acc   = (state == ST_PRESENT) & bus.blk_ready;
    assign is_last   = (mcu_count == total_q - MCU_CNT_W'(1)) & (blk_idx == LAST_IDX);
    assign mcu_end   = blk_acc & (blk_idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            total_q   <= '0;
            mcu_count <= '0;
            blk_idx   <= '0;
            pending   <= 1'b0;
            dc_reset  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dc_reset <= start_acc | restart_evt;
            if (start_acc) begin
                total_q   <= total_mcus;
                mcu_count <= '0;
                blk_idx   <= '0;
                pending   <= 1'b0;
            end
            if (tg_acc) pending <= 1'b1;
            if (blk_acc) begin
                pending <= 1'b0;
                if (blk_idx == LAST_IDX) begin
                    blk_idx <= '0;
                    if (mcu_count != total_q) mcu_count <= mcu_count + MCU_CNT_W'(1);
                end else begin
                    blk_idx <= blk_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef RESTART_INTERVAL_EN
    logic [MCU_CNT_W-1:0] ri_q, ri_cnt;

    // The final MCU never triggers a restart; the image is over.
    assign restart_evt = mcu_end & ~is_last & (ri_q != '0) & (ri_cnt == ri_q - MCU_CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ri_q         <= '0;
            ri_cnt       <= '0;
            restart_hold <= 1'b0;
        end else begin
            restart_hold <= restart_evt;
            if (start_acc) begin
                ri_q   <= restart_interval;
                ri_cnt <= '0;
            end else if (mcu_end & ~is_last & (ri_q != '0)) begin
                ri_cnt <= restart_evt ? '0 : ri_cnt + MCU_CNT_W'(1);
            end
        end
    end
`else
    assign restart_evt  = 1'b0;
    assign restart_hold = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = (total_mcus == '0) ? ST_DONE : ST_RUN;
            ST_RUN:     if (tg_acc) state_nxt = ST_PRESENT;
            ST_PRESENT: if (blk_acc) state_nxt = is_last ? ST_DONE : ST_RUN;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.blk_comp = 2'd0;
        bus.blk_qsel = 1'b0;
        if (blk_idx == CB_IDX) begin
            bus.blk_comp = 2'd1;
            bus.blk_qsel = 1'b1;
        end else if (blk_idx == LAST_IDX) begin
            bus.blk_comp = 2'd2;
            bus.blk_qsel = 1'b1;
        end
    end

    // blk_valid comes straight off the state register, one cycle after tg_valid.
    assign bus.blk_valid             = (state == ST_PRESENT);
    assign bus.blk_last              = is_last;
    assign bus.coef_ready            = (state == ST_RUN) & ~pending & ~restart_hold;
    assign bus.tg_is_new_coefficient = bus.coef_valid & bus.coef_ready;
    assign busy                      = (state != ST_IDLE);
    assign done                      = (state == ST_DONE);

endmodule

// File: tb/tb_mcu_block_scheduler.sv
// Directed bench for mcu_block_scheduler with hand-computed block tags and counts.
module tb_mcu_block_scheduler;
    localparam int MCU_CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [MCU_CNT_W-1:0] total_mcus = '0;
    logic [MCU_CNT_W-1:0] mcu_count;
    logic                 busy, done, dc_reset;
`ifdef RESTART_INTERVAL_EN
    logic [MCU_CNT_W-1:0] restart_interval = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int dc_pulses = 0;

    mcu_block_scheduler_if bus_if ();

    mcu_block_scheduler #(.Y_BLOCKS(4), .MCU_CNT_W(MCU_CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .total_mcus       (total_mcus),
`ifdef RESTART_INTERVAL_EN
        .restart_interval (restart_interval),
`endif
        .bus              (bus_if),
        .mcu_count        (mcu_count),
        .busy             (busy),
        .done             (done),
        .dc_reset         (dc_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_image(input int total);
        start      = 1'b1;
        total_mcus = MCU_CNT_W'(total);
        step();
        start = 1'b0;
        check("start_dc_reset", dc_reset, 1'b1);
        check("start_busy", busy, 1'b1);
    endtask

    // Entry/exit point: just after an acceptance (or start) edge; blk_ready must be 1.
    task automatic do_block(input logic [1:0] comp, input logic qsel, input logic last);
        if (dc_reset) begin
            dc_pulses++;
            if (mcu_count != 0) check("ri_coef_hold", bus_if.coef_ready, 1'b0);
        end
        step();
        check("run_coef_ready", bus_if.coef_ready, 1'b1);
        check("run_tg_new", bus_if.tg_is_new_coefficient, 1'b1);
        bus_if.tg_valid = 1'b1;
        step();
        bus_if.tg_valid = 1'b0;
        check("pres_valid", bus_if.blk_valid, 1'b1);
        check("pres_coef_ready", bus_if.coef_ready, 1'b0);
        check("pres_tg_new", bus_if.tg_is_new_coefficient, 1'b0);
        check("pres_comp", bus_if.blk_comp, comp);
        check("pres_qsel", bus_if.blk_qsel, qsel);
        check("pres_last", bus_if.blk_last, last);
        step();
    endtask

    task automatic run_mcu(input logic last_mcu);
        for (int i = 0; i < 4; i++) do_block(2'd0, 1'b0, 1'b0);
        do_block(2'd1, 1'b1, 1'b0);
        do_block(2'd2, 1'b1, last_mcu);
    endtask

    task automatic finish_image(input int total);
        check("done_pulse", done, 1'b1);
        check("done_mcu_count", mcu_count, total);
        check("done_blk_valid", bus_if.blk_valid, 1'b0);
        step();
        check("done_cleared", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        bus_if.coef_valid = 1'b1;
        bus_if.tg_valid   = 1'b0;
        bus_if.blk_ready  = 1'b1;

        // Reset state
        #2;
        check("rst_blk_valid", bus_if.blk_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dc_reset", dc_reset, 1'b0);
        check("rst_mcu_count", mcu_count, 0);
        check("rst_coef_ready", bus_if.coef_ready, 1'b0);
        step();
        rst = 1'b0;

        // tg_valid in IDLE is ignored
        bus_if.tg_valid = 1'b1;
        step();
        bus_if.tg_valid = 1'b0;
        check("idle_tg_ignored", bus_if.blk_valid, 1'b0);
        check("idle_tg_busy", busy, 1'b0);

        // One-MCU image, downstream always ready
        start_image(1);
        run_mcu(1'b1);
        finish_image(1);

        // Two-MCU image with 10 cycles of downstream backpressure on the first block
        start_image(2);
        step();
        check("bp_coef_ready", bus_if.coef_ready, 1'b1);
        bus_if.tg_valid  = 1'b1;
        bus_if.blk_ready = 1'b0;
        step();
        bus_if.tg_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", bus_if.blk_valid, 1'b1);
            check("bp_coef_ready", bus_if.coef_ready, 1'b0);
            check("bp_comp", bus_if.blk_comp, 2'd0);
            check("bp_qsel", bus_if.blk_qsel, 1'b0);
            check("bp_last", bus_if.blk_last, 1'b0);
            bus_if.tg_valid = (i == 3);
            step();
        end
        bus_if.tg_valid  = 1'b0;
        bus_if.blk_ready = 1'b1;
        step();
        check("bp_release_valid", bus_if.blk_valid, 1'b0);
        check("bp_release_coef", bus_if.coef_ready, 1'b1);
        for (int i = 0; i < 3; i++) do_block(2'd0, 1'b0, 1'b0);
        do_block(2'd1, 1'b1, 1'b0);
        do_block(2'd2, 1'b1, 1'b0);
        check("bp_mcu1", mcu_count, 1);
        run_mcu(1'b1);
        finish_image(2);

        // Empty image
        start_image(0);
        check("empty_done", done, 1'b1);
        check("empty_blk_valid", bus_if.blk_valid, 1'b0);
        step();
        check("empty_done_clr", done, 1'b0);
        check("empty_busy", busy, 1'b0);
        check("empty_blk_valid2", bus_if.blk_valid, 1'b0);

        // Start while busy (MCU 0, block 3) is ignored
        start_image(1);
        for (int i = 0; i < 3; i++) do_block(2'd0, 1'b0, 1'b0);
        start      = 1'b1;
        total_mcus = MCU_CNT_W'(7);
        step();
        start = 1'b0;
        check("restart_ign_busy", busy, 1'b1);
        check("restart_ign_mcu", mcu_count, 0);
        check("restart_ign_dc", dc_reset, 1'b0);
        do_block(2'd0, 1'b0, 1'b0);
        do_block(2'd1, 1'b1, 1'b0);
        do_block(2'd2, 1'b1, 1'b1);
        finish_image(1);

        // Reset while presenting MCU 1 block 4
        start_image(3);
        run_mcu(1'b0);
        for (int i = 0; i < 4; i++) do_block(2'd0, 1'b0, 1'b0);
        bus_if.blk_ready = 1'b0;
        step();
        bus_if.tg_valid = 1'b1;
        step();
        bus_if.tg_valid = 1'b0;
        check("prerst_valid", bus_if.blk_valid, 1'b1);
        check("prerst_comp", bus_if.blk_comp, 2'd1);
        check("prerst_mcu", mcu_count, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", bus_if.blk_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_mcu", mcu_count, 0);
        check("midrst_coef", bus_if.coef_ready, 1'b0);
        step();
        rst = 1'b0;
        bus_if.blk_ready = 1'b1;
        start_image(1);
        run_mcu(1'b1);
        finish_image(1);

`ifdef RESTART_INTERVAL_EN
        // Restart interval 2 over 5 MCUs: pulses at start, after MCU 2 and MCU 4
        restart_interval = MCU_CNT_W'(2);
        dc_pulses = 0;
        start_image(5);
        for (int m = 0; m < 5; m++) run_mcu(m == 4);
        check("ri_no_final_pulse", dc_reset, 1'b0);
        check("ri_pulse_count", dc_pulses, 3);
        finish_image(5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_block_scheduler.md
Name: mcu_block_scheduler

Overview:
Sequences entropy-decoded coefficients through the table generation stage, one 8x8 block at a time, in 4:2:0 MCU order: Y0, Y1, Y2, Y3, Cb, Cr.
- Gates the coefficient stream into the table generator.
- Tags each finished table with its component and quantization-table select.
- Holds off new coefficients until downstream (IDCT) accepts the current table.
- Counts MCUs to end of image.

Parameters:
Y_BLOCKS, 4, luma blocks per MCU (1..4); chroma blocks per MCU are fixed at 2.
MCU_CNT_W, 16, width of the MCU counters.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins an image
total_mcus  input  MCU_CNT_W  MCUs in the image; sampled on accepted start
coef_valid  input  1  upstream coefficient valid
coef_ready  output  1  scheduler accepts a coefficient this cycle
tg_is_new_coefficient  output  1  coef_valid & coef_ready; drives table generator
tg_valid  input  1  table generator block-complete pulse
blk_valid  output  1  finished table available to downstream
blk_ready  input  1  downstream accepts table
blk_comp  output  2  component of presented block: 0=Y, 1=Cb, 2=Cr
blk_qsel  output  1  quantization table select: 0 luma, 1 chroma
blk_last  output  1  presented block is the final block of the image
mcu_count  output  MCU_CNT_W  MCUs fully delivered
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of image
dc_reset  output  1  one-cycle pulse; clears DC predictors

Behaviour:
- Reset (async, immediate): state=IDLE; blk_valid=0, done=0, dc_reset=0, mcu_count=0, block index=0, pending=0. All outputs 0.
- States:
  - IDLE: start → RUN, latch total_mcus, clear mcu_count and block index, pulse dc_reset the next cycle. If total_mcus==0, go to DONE instead.
  - RUN: coef_ready = (state==RUN) & ~pending, combinational.
  - RUN, tg_valid seen: set pending, go to PRESENT. blk_valid is registered and rises the cycle after tg_valid.
  - PRESENT: blk_valid=1. blk_comp, blk_qsel and blk_last stay stable until blk_valid & blk_ready. On acceptance, clear pending, advance block index, return to RUN or go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Block index: runs 0..Y_BLOCKS+1.
  - Index < Y_BLOCKS: comp=0, qsel=0.
  - Index == Y_BLOCKS: comp=1, qsel=1.
  - Index == Y_BLOCKS+1: comp=2, qsel=1.
  - Accepting index Y_BLOCKS+1 wraps the index to 0 and increments mcu_count.
- blk_last = (mcu_count == total_mcus-1) & (index == Y_BLOCKS+1).
  - Acceptance of the blk_last block → DONE.
- Boundary conditions:
  - start while busy: ignored.
  - tg_valid outside RUN, or while pending: ignored; sticky error not required.
  - coef_valid while coef_ready=0: no transfer; upstream must hold.
  - blk_ready while blk_valid=0: no effect.
  - blk_valid and blk_ready both high in the cycle blk_valid rises: accepted that cycle.
  - mcu_count saturates at total_mcus.
  - rst asserted mid-block: all state discarded; the table generator is reset by the same rst.
- No coefficient is forwarded between tg_valid and downstream acceptance, so at most one table is outstanding.

Optional Feature:
RESTART_INTERVAL_EN
- Defined:
  - Adds input restart_interval [MCU_CNT_W-1:0], sampled on start.
  - Nonzero value: after every restart_interval MCUs delivered (except after the last MCU), dc_reset pulses one cycle. The pulse occurs in the cycle after the MCU-completing acceptance.
  - coef_ready is held low during that cycle.
  - Zero value: no mid-image pulses.
- Undefined: no port; dc_reset pulses only at image start.

Test Plan:
- Reset, total_mcus=1, start; stream 6 blocks, tg_valid after each; blk_ready tied 1 → blk_comp sequence 0,0,0,0,1,2, blk_qsel 0,0,0,0,1,1, blk_last only on the 6th block, done one cycle after the 6th acceptance, mcu_count=1.
- total_mcus=2, blk_ready held 0 for 10 cycles after the first tg_valid → coef_ready=0 and blk_valid=1 with fields stable for all 10 cycles; release → one acceptance, coef_ready returns 1 the next cycle.
- total_mcus=0, start → done pulses without blk_valid ever rising, then IDLE, busy=0.
- Second start pulse mid-image (MCU 0, block 3) → ignored: mcu_count and block index unchanged, image completes normally.
- Assert rst while blk_valid=1 at MCU 1, block 4 → same cycle blk_valid=0, busy=0, mcu_count=0; a new start produces Y0 first.
- With RESTART_INTERVAL_EN, restart_interval=2, total_mcus=5 → dc_reset pulses at image start and after MCUs 2 and 4; none after MCU 5.
